// File: rtl/validador_senha.sv
// Password validator: walks one shared W-bit comparator over all stored slots. The result comes on edge E0+NUM_SENHAS+1.
// No backpressure. A request is taken only in IDLE; while busy or locked out a request is dropped, never queued.
module validador_senha #(
    parameter int NUM_DIGITOS    = 20,
    parameter int NUM_SENHAS     = 5,
    parameter int MAX_TENTATIVAS = 5,
    parameter int BLOQ_TICKS     = 30,
    localparam int W             = 4 * NUM_DIGITOS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W-1:0]            senha_in,
    input  logic                    senha_valid,
    input  logic [NUM_SENHAS*W-1:0] senhas_cfg,
    input  logic                    clr_tentativas,
    input  logic                    tick_ms,
    output logic                    busy,
    output logic                    resultado_valid,
    output logic                    senha_ok,
    output logic                    master_ok,
    output logic [2:0]              slot_idx,
    output logic [2:0]              tentativas,
    output logic                    bloqueado
);

    localparam int KW = $clog2(NUM_SENHAS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARA,
        S_BLOQUEADO
    } estado_t;

    estado_t        r_estado;
    estado_t        w_prox;

    logic [W-1:0]   r_codigo;
    logic [KW-1:0]  r_k;
    logic [KW-1:0]  r_idx;
    logic           r_achou;
    logic [15:0]    r_cnt;
    logic [2:0]     r_tent;
    logic           r_res_vld;
    logic           r_ok;
    logic           r_master;
    logic [2:0]     r_slot_idx;

    logic [W-1:0]   w_slots [NUM_SENHAS];
    logic [KW-1:0]  w_sel;
    logic [W-1:0]   w_slot;
    logic           w_match;
    logic           w_fim;
    logic [2:0]     w_tent_inc;
    logic           w_bloqueia;
    logic           w_fim_bloq;

    always_comb begin
        for (int s = 0; s < NUM_SENHAS; s++) begin
            w_slots[s] = senhas_cfg[s*W +: W];
        end
    end

    // r_k runs one past the last slot; that extra cycle registers the result
    assign w_fim      = (r_k == KW'(NUM_SENHAS));
    assign w_sel      = w_fim ? '0 : r_k;
    assign w_slot     = w_slots[w_sel];
    assign w_match    = (r_codigo == w_slot) && (w_slot != '1) && (r_codigo != '1);
    assign w_tent_inc = (r_tent == 3'(MAX_TENTATIVAS)) ? r_tent : r_tent + 3'd1;
    assign w_bloqueia = !r_achou && (w_tent_inc == 3'(MAX_TENTATIVAS));
    assign w_fim_bloq = tick_ms && (r_cnt == 16'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado <= S_IDLE;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            S_IDLE: begin
                if (senha_valid) begin
                    w_prox = S_COMPARA;
                end
            end
            S_COMPARA: begin
                if (w_fim) begin
                    w_prox = w_bloqueia ? S_BLOQUEADO : S_IDLE;
                end
            end
            S_BLOQUEADO: begin
                if (w_fim_bloq) begin
                    w_prox = S_IDLE;
                end
            end
            default: w_prox = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_codigo   <= '0;
            r_k        <= '0;
            r_idx      <= '0;
            r_achou    <= 1'b0;
            r_cnt      <= '0;
            r_tent     <= '0;
            r_res_vld  <= 1'b0;
            r_ok       <= 1'b0;
            r_master   <= 1'b0;
            r_slot_idx <= '0;
        end else begin
            r_res_vld <= 1'b0;
            case (r_estado)
                S_IDLE: begin
                    if (senha_valid) begin
                        r_codigo <= senha_in;
                        r_k      <= '0;
                        r_idx    <= '0;
                        r_achou  <= 1'b0;
                    end else if (clr_tentativas) begin
                        r_tent <= '0;
                    end
                end
                S_COMPARA: begin
                    if (!w_fim) begin
                        // Keep only the lowest matching slot
                        if (w_match && !r_achou) begin
                            r_achou <= 1'b1;
                            r_idx   <= r_k;
                        end
                        r_k <= r_k + 1'b1;
                    end else begin
                        r_res_vld  <= 1'b1;
                        r_ok       <= r_achou;
                        r_master   <= r_achou && (r_idx == '0);
                        r_slot_idx <= r_achou ? 3'(r_idx) : 3'd0;
                        r_tent     <= r_achou ? 3'd0 : w_tent_inc;
                        if (w_bloqueia) begin
                            r_cnt <= 16'(BLOQ_TICKS);
                        end
                    end
                end
                S_BLOQUEADO: begin
                    if (tick_ms) begin
                        r_cnt <= r_cnt - 16'd1;
                        if (r_cnt == 16'd1) begin
                            r_tent <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy            = (r_estado != S_IDLE);
    assign bloqueado       = (r_estado == S_BLOQUEADO);
    assign resultado_valid = r_res_vld;
    assign senha_ok        = r_ok;
    assign master_ok       = r_master;
    assign slot_idx        = r_slot_idx;
    assign tentativas      = r_tent;

endmodule

// File: tb/tb_validador_senha.sv
// Directed bench for validador_senha: match, failure count, lockout, ignored requests and mid-scan reset.
module tb_validador_senha;

    localparam int ND = 20;
    localparam int NS = 5;
    localparam int W  = 4 * ND;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [W-1:0]      senha_in = '0;
    logic              senha_valid = 1'b0;
    logic [NS*W-1:0]   senhas_cfg = '1;
    logic              clr_tentativas = 1'b0;
    logic              tick_ms = 1'b0;
    logic              busy;
    logic              resultado_valid;
    logic              senha_ok;
    logic              master_ok;
    logic [2:0]        slot_idx;
    logic [2:0]        tentativas;
    logic              bloqueado;

    int n_chk = 0;
    int n_err = 0;

    validador_senha #(
        .NUM_DIGITOS(ND), .NUM_SENHAS(NS), .MAX_TENTATIVAS(5), .BLOQ_TICKS(10)
    ) dut (
        .clk(clk), .rst(rst), .senha_in(senha_in), .senha_valid(senha_valid),
        .senhas_cfg(senhas_cfg), .clr_tentativas(clr_tentativas), .tick_ms(tick_ms),
        .busy(busy), .resultado_valid(resultado_valid), .senha_ok(senha_ok),
        .master_ok(master_ok), .slot_idx(slot_idx), .tentativas(tentativas),
        .bloqueado(bloqueado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request and wait for its result; n is the count of edges from E0 to the result
    task automatic enviar(input logic [W-1:0] code, output int n);
        senha_in    = code;
        senha_valid = 1'b1;
        tick();
        senha_valid = 1'b0;
        n = 0;
        while (!resultado_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    logic [W-1:0] c1234;
    logic [W-1:0] c99;
    logic [W-1:0] callf;
    int           lat;
    int           nres;

    initial begin
        c1234 = {{16{4'hF}}, 16'h1234};
        c99   = {{18{4'hF}}, 8'h99};
        callf = '1;

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_rv", resultado_valid, 0);
        chk("rst_tent", tentativas, 0);
        chk("rst_bloq", bloqueado, 0);
        chk("rst_ok", senha_ok, 0);
        rst = 1'b1;
        tick();

        // Master match; result exactly 6 edges after capture
        senhas_cfg[0*W +: W] = c1234;
        enviar(c1234, lat);
        chk("m_lat", lat, 6);
        chk("m_ok", senha_ok, 1);
        chk("m_master", master_ok, 1);
        chk("m_idx", slot_idx, 0);
        chk("m_tent", tentativas, 0);
        tick();
        chk("m_rv_pulse", resultado_valid, 0);
        chk("m_busy", busy, 0);
        chk("m_ok_hold", senha_ok, 1);

        // User slot 3, then lowest-match priority with slot 1
        senhas_cfg[3*W +: W] = c99;
        enviar(c99, lat);
        chk("u3_lat", lat, 6);
        chk("u3_ok", senha_ok, 1);
        chk("u3_master", master_ok, 0);
        chk("u3_idx", slot_idx, 3);
        tick();
        senhas_cfg[1*W +: W] = c99;
        enviar(c99, lat);
        chk("u1_idx", slot_idx, 1);
        chk("u1_master", master_ok, 0);
        tick();

        // All-F never matches, even against all-F slots
        senhas_cfg = '1;
        enviar(callf, lat);
        chk("f_ok", senha_ok, 0);
        chk("f_idx", slot_idx, 0);
        chk("f_tent", tentativas, 1);
        tick();
        clr_tentativas = 1'b1;
        tick();
        clr_tentativas = 1'b0;
        chk("clr_tent", tentativas, 0);

        // Five failures lock out; a tick on the load edge is ignored
        senhas_cfg[0*W +: W] = c1234;
        for (int i = 1; i <= 4; i++) begin
            enviar(c99, lat);
            chk($sformatf("w%0d_tent", i), tentativas, i);
            chk($sformatf("w%0d_bloq", i), bloqueado, 0);
            tick();
        end
        tick_ms = 1'b1;
        enviar(c99, lat);
        tick_ms = 1'b0;
        chk("w5_lat", lat, 6);
        chk("w5_bloq", bloqueado, 1);
        chk("w5_tent", tentativas, 5);
        chk("w5_busy", busy, 1);
        senha_in = c1234;
        senha_valid = 1'b1;
        clr_tentativas = 1'b1;
        tick();
        senha_valid = 1'b0;
        clr_tentativas = 1'b0;
        nres = 0;
        for (int i = 0; i < 10; i++) begin
            if (resultado_valid) nres++;
            tick();
        end
        chk("blq_nores", nres, 0);
        chk("blq_tent", tentativas, 5);
        for (int i = 1; i <= 10; i++) begin
            tick_ms = 1'b1;
            tick();
            tick_ms = 1'b0;
            if (i == 9) chk("blq_t9", bloqueado, 1);
            if (i < 10) tick();
        end
        chk("blq_end", bloqueado, 0);
        chk("blq_end_tent", tentativas, 0);
        chk("blq_end_busy", busy, 0);
        tick();

        // Request during the scan is dropped; back-to-back request is accepted
        senha_in = c1234;
        senha_valid = 1'b1;
        tick();
        senha_valid = 1'b0;
        tick();
        tick();
        senha_in = c99;
        senha_valid = 1'b1;
        tick();
        senha_valid = 1'b0;
        senha_in = c1234;
        lat = 3;
        while (!resultado_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("ign_lat", lat, 6);
        chk("ign_ok", senha_ok, 1);
        enviar(c99, lat);
        chk("b2b_lat", lat, 6);
        chk("b2b_ok", senha_ok, 0);
        chk("b2b_tent", tentativas, 1);
        tick();
        nres = 0;
        for (int i = 0; i < 8; i++) begin
            if (resultado_valid) nres++;
            tick();
        end
        chk("ign_single", nres, 0);

        // Reset in the middle of a scan
        enviar(c1234, lat);
        chk("pre_rst_ok", senha_ok, 1);
        tick();
        senha_in = c1234;
        senha_valid = 1'b1;
        tick();
        senha_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_ok", senha_ok, 0);
        chk("mr_master", master_ok, 0);
        chk("mr_rv", resultado_valid, 0);
        #3;
        rst = 1'b1;
        nres = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (resultado_valid) nres++;
        end
        chk("mr_nores", nres, 0);
        chk("mr_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
